// File: rtl/crypto_round_engine.sv
// crypto_round_engine: round-based block-cipher controller (ADDK -> SUB -> MIX per round, then FINAL).
// Latency: capture edge to out_valid is 1 + ROUNDS*(2 + ceil(NBYTES/SBOX_LANES)) cycles; accepts one block at a time.
// Backpressure: in_ready only in IDLE; in DONE, out_valid and dout hold until out_ready, then back to IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/din/key/mode input handshake;
//        out_valid/out_ready/dout output handshake; busy, round_cnt, blocks_done status.
// Optional feature macro: CRYPTO_ENGINE_ZEROIZE_EN clears dout, state and round key on the output handshake.
module crypto_round_engine #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ROUNDS     = 16,
  parameter int unsigned SBOX_LANES = 16,
  parameter logic [31:0] RCON       = 32'h1B1B_1B1B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] key,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic [4:0]        round_cnt,
  output logic [15:0]       blocks_done
);

  localparam int unsigned NBYTES = DATA_W / 8;
  // Pointer must hold ptr + SBOX_LANES without overflow for the end-of-SUB test.
  localparam int unsigned PTR_W  = $clog2(NBYTES + SBOX_LANES + 1);
  localparam logic [PTR_W-1:0]  LANES_P  = PTR_W'(SBOX_LANES);
  localparam logic [PTR_W-1:0]  NBYTES_P = PTR_W'(NBYTES);
  localparam logic [4:0]        ROUNDS_P = 5'(ROUNDS);
  localparam logic [DATA_W-1:0] RCON_W   = DATA_W'(RCON);

  typedef enum logic [2:0] {IDLE, ADDK, SUB, MIX, FINAL, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [DATA_W-1:0] rk_q, rk_d;
  logic [1:0]        md_q, md_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [4:0]        round_q, round_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [15:0]       blocks_done_q, blocks_done_d;
  logic [DATA_W-1:0] sub_st;
  logic [DATA_W-1:0] mix_st;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b[3:0])
      4'h0: s = 8'h63;  4'h1: s = 8'h7C;  4'h2: s = 8'h77;  4'h3: s = 8'h7B;
      4'h4: s = 8'hF2;  4'h5: s = 8'h6B;  4'h6: s = 8'h6F;  4'h7: s = 8'hC5;
      4'h8: s = 8'h30;  4'h9: s = 8'h01;  4'hA: s = 8'h67;  4'hB: s = 8'h2B;
      4'hC: s = 8'hFE;  4'hD: s = 8'hD7;  4'hE: s = 8'hAB;  4'hF: s = 8'h76;
      default: s = 8'h00;
    endcase
    return s ^ {4'h0, b[7:4]};
  endfunction

  // Only the lanes in the current pointer window are substituted; the last
  // window may run past NBYTES, those lanes simply do not exist.
  always_comb begin
    sub_st = st_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (PTR_W'(i) >= ptr_q && PTR_W'(i) < ptr_q + LANES_P) begin
        sub_st[8*i +: 8] = sub_byte(st_q[8*i +: 8]);
      end
    end
  end

  always_comb begin
    mix_st = st_q;
    case (md_q)
      2'd0:    mix_st = st_q ^ rk_q;
      2'd1:    mix_st = {st_q[DATA_W-2:0], st_q[DATA_W-1]};
      2'd2:    mix_st = st_q + rk_q;
      default: mix_st = ~st_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    rk_d          = rk_q;
    md_d          = md_q;
    ptr_d         = ptr_q;
    round_d       = round_q;
    dout_d        = dout_q;
    blocks_done_d = blocks_done_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = din;
          rk_d    = key;
          md_d    = mode;
          round_d = 5'd0;
          ptr_d   = '0;
          state_d = ADDK;
        end
      end
      ADDK: begin
        st_d    = st_q ^ rk_q;
        rk_d    = {rk_q[DATA_W-9:0], rk_q[DATA_W-1:DATA_W-8]} ^ RCON_W;
        state_d = SUB;
      end
      SUB: begin
        st_d = sub_st;
        if (ptr_q + LANES_P >= NBYTES_P) begin
          ptr_d   = '0;
          state_d = MIX;
        end else begin
          ptr_d = ptr_q + LANES_P;
        end
      end
      MIX: begin
        st_d    = mix_st;
        round_d = round_q + 5'd1;
        state_d = (round_q + 5'd1 < ROUNDS_P) ? ADDK : FINAL;
      end
      FINAL: begin
        dout_d  = st_q ^ rk_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          blocks_done_d = blocks_done_q + 16'd1;
          state_d       = IDLE;
`ifdef CRYPTO_ENGINE_ZEROIZE_EN
          dout_d = '0;
          st_d   = '0;
          rk_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      st_q          <= '0;
      rk_q          <= '0;
      md_q          <= 2'd0;
      ptr_q         <= '0;
      round_q       <= 5'd0;
      dout_q        <= '0;
      blocks_done_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      st_q          <= st_d;
      rk_q          <= rk_d;
      md_q          <= md_d;
      ptr_q         <= ptr_d;
      round_q       <= round_d;
      dout_q        <= dout_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign dout        = dout_q;
  assign round_cnt   = round_q;
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_crypto_round_engine.sv
// Testbench for crypto_round_engine: a 16-bit/1-round instance and a 128-bit/16-round/4-lane instance.
// Expected ciphertexts are pushed to a scoreboard at capture and popped at out_valid.
// Set CRYPTO_ENGINE_ZEROIZE_EN on the whole build to exercise the zeroize variant.
module tb_crypto_round_engine;

  localparam logic [7:0] SBOX [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                                       8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};

  logic clk;
  logic rst;

  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [15:0]  s_din, s_key, s_dout, s_blocks_done;
  logic [1:0]   s_mode;
  logic [4:0]   s_round_cnt;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_din, b_key, b_dout;
  logic [15:0]  b_blocks_done;
  logic [1:0]   b_mode;
  logic [4:0]   b_round_cnt;

  logic [127:0] sb_q[$];
  logic [127:0] exp_v;
  logic [127:0] rd, rk;
  int checks = 0;
  int passes = 0;
  int n;

  crypto_round_engine #(.DATA_W(16), .ROUNDS(1), .SBOX_LANES(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .din(s_din), .key(s_key),
    .mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .busy(s_busy),
    .round_cnt(s_round_cnt), .blocks_done(s_blocks_done)
  );

  crypto_round_engine #(.DATA_W(128), .ROUNDS(16), .SBOX_LANES(4)) u_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din), .key(b_key),
    .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .busy(b_busy),
    .round_cnt(b_round_cnt), .blocks_done(b_blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_model(input int nbits, input int rounds, input logic [127:0] d,
                                             input logic [127:0] k, input logic [1:0] m);
    logic [127:0] mask, rc, st, kk;
    logic [7:0]   b;
    mask = (nbits == 128) ? {128{1'b1}} : ((128'd1 << nbits) - 128'd1);
    rc   = 128'(32'h1B1B_1B1B) & mask;
    st   = d & mask;
    kk   = k & mask;
    for (int r = 0; r < rounds; r++) begin
      st = st ^ kk;
      kk = (((kk << 8) | (kk >> (nbits - 8))) & mask) ^ rc;
      for (int i = 0; i < nbits / 8; i++) begin
        b = st[8*i +: 8];
        st[8*i +: 8] = SBOX[b[3:0]] ^ {4'h0, b[7:4]};
      end
      case (m)
        2'd0:    st = st ^ kk;
        2'd1:    st = ((st << 1) | (st >> (nbits - 1))) & mask;
        2'd2:    st = (st + kk) & mask;
        default: st = ~st & mask;
      endcase
    end
    return (st ^ kk) & mask;
  endfunction

  task automatic cyc(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, want);
  endtask

  task automatic send_s(input logic [15:0] d, input logic [15:0] k, input logic [1:0] m);
    s_din = d; s_key = k; s_mode = m; s_in_valid = 1'b1;
    cyc(1);
    s_in_valid = 1'b0; s_din = 16'hA5A5; s_key = 16'h5A5A; s_mode = 2'd0;
  endtask

  task automatic send_b(input logic [127:0] d, input logic [127:0] k, input logic [1:0] m);
    b_din = d; b_key = k; b_mode = m; b_in_valid = 1'b1;
    cyc(1);
    b_in_valid = 1'b0; b_din = ~d; b_key = ~k; b_mode = ~m;
  endtask

  task automatic wait_s(output int cnt);
    cnt = 0;
    while (s_out_valid !== 1'b1 && cnt < 300) begin
      cyc(1);
      cnt++;
    end
  endtask

  task automatic wait_b(output int cnt);
    cnt = 0;
    while (b_out_valid !== 1'b1 && cnt < 300) begin
      cyc(1);
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    s_in_valid = 1'b0; s_din = '0; s_key = '0; s_mode = '0; s_out_ready = 1'b0;
    b_in_valid = 1'b0; b_din = '0; b_key = '0; b_mode = '0; b_out_ready = 1'b0;
    cyc(3);

    // Reset state
    check("rst_in_ready", 128'(s_in_ready), 128'd1);
    check("rst_out_valid", 128'(s_out_valid), 128'd0);
    check("rst_dout", 128'(s_dout), 128'd0);
    check("rst_busy", 128'(s_busy), 128'd0);
    check("rst_round_cnt", 128'(s_round_cnt), 128'd0);
    check("rst_blocks_done", 128'(s_blocks_done), 128'd0);
    check("rst_big_in_ready", 128'(b_in_ready), 128'd1);
    rst = 1'b0;
    cyc(1);

    // Basic vector, sink always ready
    s_out_ready = 1'b1;
    sb_q.push_back(128'h8787);
    send_s(16'h0000, 16'h0000, 2'd3);
    check("basic_busy", 128'(s_busy), 128'd1);
    check("basic_in_ready_busy", 128'(s_in_ready), 128'd0);
    wait_s(n);
    check("basic_latency", 128'(n), 128'd4);
    exp_v = sb_q.pop_front();
    check("basic_dout", 128'(s_dout), exp_v);
    cyc(1);
    check("basic_out_valid_drop", 128'(s_out_valid), 128'd0);
    check("basic_blocks_done", 128'(s_blocks_done), 128'd1);
    check("basic_in_ready_after", 128'(s_in_ready), 128'd1);
    check("basic_round_cnt_hold", 128'(s_round_cnt), 128'd1);
`ifdef CRYPTO_ENGINE_ZEROIZE_EN
    check("zeroize_dout", 128'(s_dout), 128'h0);
`else
    check("dout_retained", 128'(s_dout), 128'h8787);
`endif

    // Backpressure: sink stalls 10 cycles; source offers a different block meanwhile
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    s_out_ready = 1'b0;
    sb_q.push_back(128'h8787);
    send_s(16'h0000, 16'h0000, 2'd3);
    wait_s(n);
    check("bp_latency", 128'(n), 128'd4);
    exp_v = sb_q.pop_front();
    s_din = 16'hFFFF; s_key = 16'h1234; s_mode = 2'd1; s_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check($sformatf("bp_out_valid_%0d", k), 128'(s_out_valid), 128'd1);
      check($sformatf("bp_dout_%0d", k), 128'(s_dout), exp_v);
      check($sformatf("bp_in_ready_%0d", k), 128'(s_in_ready), 128'd0);
      check($sformatf("bp_blocks_done_%0d", k), 128'(s_blocks_done), 128'd0);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    cyc(1);
    check("bp_blocks_done_after", 128'(s_blocks_done), 128'd1);
    check("bp_out_valid_after", 128'(s_out_valid), 128'd0);

    // Four modes on the wide, multi-cycle-SUB instance
    b_out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      sb_q.push_back(ref_model(128, 16, rd, rk, 2'(m)));
      send_b(rd, rk, 2'(m));
      wait_b(n);
      check($sformatf("lanes_latency_m%0d", m), 128'(n), 128'd97);
      check($sformatf("lanes_round_cnt_m%0d", m), 128'(b_round_cnt), 128'd16);
      exp_v = sb_q.pop_front();
      check($sformatf("lanes_dout_m%0d", m), b_dout, exp_v);
      cyc(1);
      check($sformatf("lanes_blocks_done_m%0d", m), 128'(b_blocks_done), 128'(m + 1));
    end

    // Reset in the middle of round 5 discards the block
    rd = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    sb_q.push_back(ref_model(128, 16, rd, rk, 2'd2));
    send_b(rd, rk, 2'd2);
    n = 0;
    while (b_round_cnt !== 5'd5 && n < 300) begin
      cyc(1);
      n++;
    end
    check("midrst_reached_round5", 128'(b_round_cnt), 128'd5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    void'(sb_q.pop_back());
    check("midrst_out_valid", 128'(b_out_valid), 128'd0);
    check("midrst_dout", b_dout, 128'd0);
    check("midrst_in_ready", 128'(b_in_ready), 128'd1);
    check("midrst_busy", 128'(b_busy), 128'd0);
    check("midrst_round_cnt", 128'(b_round_cnt), 128'd0);
    rd = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    sb_q.push_back(ref_model(128, 16, rd, rk, 2'd1));
    send_b(rd, rk, 2'd1);
    wait_b(n);
    check("midrst_new_latency", 128'(n), 128'd97);
    exp_v = sb_q.pop_front();
    check("midrst_new_dout", b_dout, exp_v);
    cyc(1);
    check("midrst_new_blocks_done", 128'(b_blocks_done), 128'd1);

    // Completed-block counter wrap
    force u_small.blocks_done_q = 16'hFFFF;
    cyc(1);
    release u_small.blocks_done_q;
    cyc(1);
    check("wrap_preload", 128'(s_blocks_done), 128'hFFFF);
    s_out_ready = 1'b1;
    rd = 128'($urandom_range(0, 65535));
    rk = 128'($urandom_range(0, 65535));
    sb_q.push_back(ref_model(16, 1, rd, rk, 2'd2));
    send_s(rd[15:0], rk[15:0], 2'd2);
    wait_s(n);
    check("wrap_latency", 128'(n), 128'd4);
    exp_v = sb_q.pop_front();
    check("wrap_dout", 128'(s_dout), exp_v);
    cyc(1);
    check("wrap_blocks_done", 128'(s_blocks_done), 128'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/crypto_round_engine.md
Name: crypto_round_engine

Overview:
Parametrised round-based block-cipher controller, the next generation of the single-byte crypto host. Width, round count, S-box lanes per cycle and round constant are all configurable. It adds valid/ready handshakes on both input and output, with output backpressure, an on-the-fly round-key schedule and a completed-block counter. It sits between the block-data source and the ciphertext sink inside the crypto host.

Parameters:
DATA_W, 128, block and key width in bits; multiple of 8, minimum 16.
ROUNDS, 16, number of rounds; 1..31.
SBOX_LANES, 16, bytes substituted per SUB cycle; 1..DATA_W/8.
RCON, 32'h1B1B_1B1B, round constant; zero-extended or truncated to DATA_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  source offers a block
in_ready  out  1  engine idle, can accept
din  in  DATA_W  plaintext
key  in  DATA_W  cipher key, sampled with din
mode  in  2  0=xor-key, 1=rotate, 2=add-key, 3=invert; sampled with din
out_valid  out  1  ciphertext available
out_ready  in  1  sink accepts
dout  out  DATA_W  ciphertext
busy  out  1  high in any state except IDLE
round_cnt  out  5  current round index
blocks_done  out  16  count of completed output handshakes

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge.
- Reset values: in_ready=1 (IDLE), out_valid=0, dout=0, busy=0, round_cnt=0, blocks_done=0. Internal state, round key and mode registers are 0.
- Reset mid-operation: the block in flight is discarded with no output, and the engine returns to IDLE.
- Internally, NBYTES=DATA_W/8 and SUB_CYC=ceil(NBYTES/SBOX_LANES).
- FSM states: IDLE, ADDK, SUB, MIX, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, load st<=din, rk<=key, md<=mode, round_cnt<=0, byte pointer<=0, then go to ADDK. in_ready is combinationally equal to (state==IDLE).
- ADDK: st<=st^rk; rk<=rotl(rk,8)^RCON. Go to SUB.
- SUB: lanes ptr..ptr+SBOX_LANES-1 are substituted; lanes at or beyond NBYTES are untouched. Each byte b becomes S[b[3:0]] ^ {4'h0,b[7:4]}.
  - S table: 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76.
  - ptr advances by SBOX_LANES each cycle. After SUB_CYC cycles, ptr resets to 0 and the FSM goes to MIX.
- MIX, selected by md:
  - 0: st^rk
  - 1: rotl(st,1)
  - 2: st+rk, mod 2^DATA_W
  - 3: ~st
  - round_cnt increments. Go to ADDK if round_cnt+1<ROUNDS, else to FINAL.
- FINAL: dout<=st^rk; out_valid<=1. Go to DONE.
- DONE: out_valid and dout hold stable until out_ready. On out_valid&out_ready: out_valid<=0, blocks_done++ (wraps FFFF->0000), go to IDLE.
- No IDLE bypass: the earliest next accept is the cycle after the output handshake.
- Latency from the capture edge to out_valid high is 1+ROUNDS*(2+SUB_CYC) cycles. With defaults this is 49.
- din, key and mode changes after capture have no effect. in_valid while busy is ignored, and the source must hold it.
- dout keeps its last value after the handshake, unless the optional feature below is enabled.
- round_cnt holds its final value (ROUNDS) until the next capture.

Optional Feature:
CRYPTO_ENGINE_ZEROIZE_EN
- Defined: on the out handshake edge, dout, st and rk are cleared to 0 in the same edge that drops out_valid. On any reset they are cleared as normal.
- Undefined: dout retains the last ciphertext until the next FINAL. st and rk are not cleared.

Test Plan:
- Basic vector, params DATA_W=16, ROUNDS=1, SBOX_LANES=2. Stimulus: din=0x0000, key=0x0000, mode=3, out_ready=1. Required: out_valid rises exactly 4 cycles after capture, dout=0x8787, blocks_done=1, in_ready=1 the following cycle.
- Backpressure: same setup with out_ready=0 for 10 cycles. Required: out_valid and dout=0x8787 stable for all 10 cycles, in_ready=0, blocks_done=0; after out_ready=1, blocks_done=1.
- Lanes, params DATA_W=128, ROUNDS=16, SBOX_LANES=4. Required: SUB lasts 4 cycles, latency is 97 cycles, and dout matches the reference model for all 4 modes with random din and key.
- Reset mid-round: assert rst at round_cnt=5. Required: next cycle out_valid=0, dout=0, in_ready=1, busy=0; a new block then completes with the correct result.
- Counter wrap: preload the bench for 65536 handshakes (or force blocks_done=FFFF). Required: next handshake gives blocks_done=0000.
- Zeroize: with CRYPTO_ENGINE_ZEROIZE_EN, after the out handshake of the basic vector, dout=0x0000. Without it, dout stays 0x8787.
